inst_cache: RTL

Direct-mapped, read-only instruction cache that answers the fetch stage's cache read port (`read_en`/`addr_read` in, `ready`/`data_out` back). Hits respond combinationally in the same cycle. Misses stall the fetch stage by holding `ready` low while a refill FSM fetches the whole line from the memory side in order. It sits between the IF stage and the instruction memory bus adapter.

---
 rtl/inst_cache.sv | 129 ++++++++++++
 1 files changed

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with in-order line refill
module inst_cache #(
    parameter int LINE_WIDTH = 8,
    parameter int LINE_COUNT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic [31:0] addr_read,
    input  logic        flush,
    output logic        ready,
    output logic [31:0] data_out,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);
    localparam int O     = $clog2(LINE_WIDTH);
    localparam int I     = $clog2(LINE_COUNT);
    localparam int T     = 32 - O - I - 2;
    localparam int WORDS = LINE_COUNT * LINE_WIDTH;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [O-1:0]            cnt_q, cnt_d;
    logic                    discard_q, discard_d;
    logic [31:0]             base_q, base_d;
    logic [LINE_COUNT-1:0]   valid_q, valid_d;
    logic [31:0]             data_q [WORDS];
    logic [T-1:0]            tag_q [LINE_COUNT];

    logic [O-1:0] req_off;
    logic [I-1:0] req_idx;
    logic [T-1:0] req_tag;
    logic [I-1:0] fill_idx;
    logic [T-1:0] fill_tag;
    logic         hit;
    logic         beat;
    logic         last_beat;
    logic         unused_addr;

    assign req_off     = addr_read[O+1:2];
    assign req_idx     = addr_read[O+I+1:O+2];
    assign req_tag     = addr_read[31:O+I+2];
    assign fill_idx    = base_q[O+I+1:O+2];
    assign fill_tag    = base_q[31:O+I+2];
    assign unused_addr = ^addr_read[1:0];

    assign hit       = read_en && valid_q[req_idx] && (tag_q[req_idx] == req_tag) && (state_q == IDLE);
    assign beat      = (state_q == REFILL) && mem_valid;
    assign last_beat = beat && (cnt_q == O'(LINE_WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        base_d      = base_q;
        valid_d     = valid_q;
        ready       = 1'b0;
        data_out    = 32'h0;
        mem_read_en = 1'b0;
        mem_addr    = 32'h0;
        if (rst) begin
            mem_addr = base_q;
            case (state_q)
                IDLE: begin
                    ready = !read_en || hit;
                    if (hit) begin
                        data_out = data_q[{req_idx, req_off}];
                    end
                    if (flush) begin
                        valid_d = '0;
                    end
                    if (read_en && !hit) begin
                        base_d  = {addr_read[31:O+2], {(O+2){1'b0}}};
                        cnt_d   = '0;
                        state_d = REFILL;
                    end
                end
                REFILL: begin
                    mem_read_en = 1'b1;
                    if (flush) begin
                        valid_d   = '0;
                        discard_d = 1'b1;
                    end
                    if (beat) begin
                        cnt_d = cnt_q + O'(1);
                    end
                    // A flush on the final beat itself also discards the line.
                    if (last_beat) begin
                        if (!discard_q && !flush) begin
                            valid_d[fill_idx] = 1'b1;
                        end
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            base_q    <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            base_q    <= base_d;
            valid_q   <= valid_d;
        end
    end

    // Data and tag arrays are never cleared; only the valid bits guard them.
    always_ff @(posedge clk) begin
        if (rst && beat) begin
            data_q[{fill_idx, cnt_q}] <= mem_data;
        end
        if (rst && last_beat) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end
endmodule
